mem_wait_stage: RTL



---
 rtl/mem_wait_pkg.sv | 12 +
 rtl/wait_counter.sv | 22 ++
 rtl/mem_wait_stage.sv | 101 ++++++++++
 3 files changed

// File: rtl/mem_wait_pkg.sv
// Shared types and encodings for the memory wait stage.
package mem_wait_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR  = 32'hE1A00000;
  localparam logic [1:0]  LDST_CLASS = 2'b01;

endpackage

// File: rtl/wait_counter.sv
// Saturating up-counter measuring how long a memory access has been waiting.
module wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_wait_stage.sv
// Pipeline stage that squashes mispredicted instructions and holds loads/stores
// until the memory side completes or the wait times out.
//
// state   | meaning
// IDLE    | ready to accept an instruction from upstream
// WAIT    | load/store outstanding, waiting for mem_rdy
import mem_wait_pkg::*;

module mem_wait_stage #(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               valid_in,
  input  logic               branch_ref,
  input  logic               branch_in,
  input  logic               sel_stall,
  input  logic               mem_rdy,
  output logic               mem_req,
  output logic               stall_out,
  output logic               valid_out,
  output logic [INSTR_W-1:0] instr_output,
  output logic               branch_value,
  output logic [CNT_W-1:0]   wait_cycles,
  output logic               timeout_err
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             is_wait;
  logic             squash;
  logic             is_ldst;
  logic             at_timeout;
  logic             cnt_clr;
  logic             cnt_en;

  assign is_wait    = (state == ST_WAIT);
  assign squash     = (branch_in != branch_ref);
  assign is_ldst    = (instr_in[27:26] == LDST_CLASS);
  assign at_timeout = (count == CNT_W'(TIMEOUT));

  assign mem_req   = is_wait;
  assign stall_out = is_wait | sel_stall;

  assign cnt_clr = !is_wait && !sel_stall && valid_in && !squash && is_ldst;
  assign cnt_en  = is_wait && !sel_stall && !mem_rdy && !at_timeout;

  wait_counter #(
    .CNT_W(CNT_W)
  ) u_wait_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(count)
  );

  // The held load/store sits in instr_output with valid_out low until it completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      instr_output <= INSTR_W'(NOP_INSTR);
      valid_out    <= 1'b0;
      branch_value <= 1'b0;
      wait_cycles  <= '0;
      timeout_err  <= 1'b0;
    end else if (!sel_stall) begin
      if (!is_wait) begin
        valid_out <= 1'b0;
        if (valid_in) begin
          branch_value <= branch_in;
          if (squash) begin
            instr_output <= INSTR_W'(NOP_INSTR);
          end else begin
            instr_output <= instr_in;
            if (is_ldst) begin
              state <= ST_WAIT;
            end else begin
              valid_out <= 1'b1;
            end
          end
        end
      end else if (mem_rdy) begin
        // completion beats a timeout landing on the same cycle
        state       <= ST_IDLE;
        valid_out   <= 1'b1;
        wait_cycles <= count;
      end else if (at_timeout) begin
        state        <= ST_IDLE;
        timeout_err  <= 1'b1;
        instr_output <= INSTR_W'(NOP_INSTR);
        valid_out    <= 1'b0;
        wait_cycles  <= CNT_W'(TIMEOUT);
      end
    end
  end

endmodule
